// File: rtl/anabellek_hakem_pkg.sv
// Shared types for the main-memory arbiter: FSM states,
// requester ids and the latched transaction bundle.
package anabellek_paket;

  localparam int OBEK_GENISLIK  = 128;
  localparam int ADRES_GENISLIK = 32;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    BEKLE = 2'd2,
    YANIT = 2'd3
  } state_e;

  typedef enum logic {
    GETIR = 1'b0,
    VERI  = 1'b1
  } sahip_e;

  typedef struct packed {
    sahip_e                    sahip;
    logic                      yaz;
    logic [ADRES_GENISLIK-1:0] adres;
    logic [OBEK_GENISLIK-1:0]  obek;
  } islem_t;

endpackage

// File: rtl/anabellek_hakem.sv
// Round-robin arbiter for the shared 128-bit main-memory block
// port, with per-transaction timeout and registered responses.
module anabellek_hakem
  import anabellek_paket::*;
#(
  parameter int ZAMAN_ASIMI = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      getir_istek_i,
  input  logic [ADRES_GENISLIK-1:0] getir_adres_i,
  output logic                      getir_musait_o,
  output logic                      getir_hazir_o,
  output logic [OBEK_GENISLIK-1:0]  getir_obek_o,
  input  logic                      veri_istek_i,
  input  logic [ADRES_GENISLIK-1:0] veri_adres_i,
  input  logic                      veri_yaz_i,
  input  logic [OBEK_GENISLIK-1:0]  veri_yaz_obek_i,
  output logic                      veri_musait_o,
  output logic                      veri_hazir_o,
  output logic [OBEK_GENISLIK-1:0]  veri_obek_o,
  output logic                      bellek_istek_o,
  output logic [ADRES_GENISLIK-1:0] bellek_adres_o,
  output logic                      bellek_yaz_o,
  output logic                      bellek_oku_o,
  output logic [OBEK_GENISLIK-1:0]  bellek_yaz_obek_o,
  input  logic                      bellek_kabul_i,
  input  logic                      bellek_hazir_i,
  input  logic [OBEK_GENISLIK-1:0]  bellek_obek_i,
  output logic                      hata_o
);

  localparam int SW = $clog2(ZAMAN_ASIMI + 1);
  localparam logic [SW-1:0] SINIR = SW'(ZAMAN_ASIMI);
  localparam logic [ADRES_GENISLIK-1:0] HIZA =
    {{(ADRES_GENISLIK-4){1'b1}}, 4'h0};

  state_e                   durum_q, durum_d;
  islem_t                   islem_q, islem_d;
  sahip_e                   son_q, son_d;
  logic [OBEK_GENISLIK-1:0] yanit_q, yanit_d;
  logic [SW-1:0]            sayac_q, sayac_d;
  logic                     hata_q, hata_d;

  logic          veri_sec;
  logic [SW-1:0] sayac_art;
  logic          doldu;

  // Tie goes to whoever was not granted last.
  assign veri_sec  = veri_istek_i &
                     (~getir_istek_i | (son_q == GETIR));
  assign sayac_art = sayac_q + SW'(1);
  assign doldu     = (sayac_art == SINIR);

  always_comb begin
    durum_d = durum_q;
    islem_d = islem_q;
    son_d   = son_q;
    yanit_d = yanit_q;
    sayac_d = sayac_q;
    hata_d  = 1'b0;
    unique case (durum_q)
      BOSTA: begin
        if (getir_istek_i | veri_istek_i) begin
          islem_d.sahip = veri_sec ? VERI : GETIR;
          islem_d.yaz   = veri_sec & veri_yaz_i;
          islem_d.adres = veri_sec ? (veri_adres_i & HIZA)
                                   : (getir_adres_i & HIZA);
          islem_d.obek  = veri_sec ? veri_yaz_obek_i : '0;
          son_d         = veri_sec ? VERI : GETIR;
          sayac_d       = '0;
          durum_d       = ISTEK;
        end
      end
      ISTEK: begin
        sayac_d = sayac_art;
        if (bellek_kabul_i && bellek_hazir_i) begin
          durum_d = YANIT;
          yanit_d = islem_q.yaz ? '0 : bellek_obek_i;
        end else if (doldu) begin
          durum_d = YANIT;
          yanit_d = '0;
          hata_d  = 1'b1;
        end else if (bellek_kabul_i) begin
          durum_d = BEKLE;
        end
      end
      BEKLE: begin
        sayac_d = sayac_art;
        if (bellek_hazir_i) begin
          durum_d = YANIT;
          yanit_d = islem_q.yaz ? '0 : bellek_obek_i;
        end else if (doldu) begin
          durum_d = YANIT;
          yanit_d = '0;
          hata_d  = 1'b1;
        end
      end
      YANIT: begin
        durum_d = BOSTA;
      end
      default: begin
        durum_d = BOSTA;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q <= BOSTA;
      islem_q <= '0;
      son_q   <= GETIR;
      yanit_q <= '0;
      sayac_q <= '0;
      hata_q  <= 1'b0;
    end else begin
      durum_q <= durum_d;
      islem_q <= islem_d;
      son_q   <= son_d;
      yanit_q <= yanit_d;
      sayac_q <= sayac_d;
      hata_q  <= hata_d;
    end
  end

  logic bosta, istek, yanit;

  assign bosta = (durum_q == BOSTA);
  assign istek = (durum_q == ISTEK);
  assign yanit = (durum_q == YANIT);

  // Gated by reset so both stay low while held in reset.
  assign getir_musait_o = bosta & rst_i;
  assign veri_musait_o  = bosta & rst_i;

  assign bellek_istek_o    = istek;
  assign bellek_adres_o    = istek ? islem_q.adres : '0;
  assign bellek_yaz_o      = istek & islem_q.yaz;
  assign bellek_oku_o      = istek & ~islem_q.yaz;
  assign bellek_yaz_obek_o = istek ? islem_q.obek : '0;

  assign getir_hazir_o = yanit & (islem_q.sahip == GETIR);
  assign veri_hazir_o  = yanit & (islem_q.sahip == VERI);
  assign getir_obek_o  = getir_hazir_o ? yanit_q : '0;
  assign veri_obek_o   = veri_hazir_o ? yanit_q : '0;
  assign hata_o        = hata_q;

endmodule

// File: tb/tb_anabellek_hakem.sv
// Scoreboard bench for anabellek_hakem: directed requests, a
// small memory model and a monitor checking every hazir pulse.
module tb_anabellek_hakem;

  logic         clk;
  logic         rst;
  logic         getir_istek;
  logic [31:0]  getir_adres;
  logic         getir_musait_o;
  logic         getir_hazir_o;
  logic [127:0] getir_obek_o;
  logic         veri_istek;
  logic [31:0]  veri_adres;
  logic         veri_yaz;
  logic [127:0] veri_yaz_obek;
  logic         veri_musait_o;
  logic         veri_hazir_o;
  logic [127:0] veri_obek_o;
  logic         bellek_istek_o;
  logic [31:0]  bellek_adres_o;
  logic         bellek_yaz_o;
  logic         bellek_oku_o;
  logic [127:0] bellek_yaz_obek_o;
  logic         bellek_kabul;
  logic         bellek_hazir;
  logic [127:0] bellek_obek;
  logic         hata_o;

  // memory model outputs and manual overrides
  logic         mem_en;
  logic         m_kabul, m_hazir, man_kabul, man_hazir;
  logic [127:0] m_obek, man_obek;

  assign bellek_kabul = mem_en ? m_kabul : man_kabul;
  assign bellek_hazir = mem_en ? m_hazir : man_hazir;
  assign bellek_obek  = mem_en ? m_obek : man_obek;

  anabellek_hakem #(.ZAMAN_ASIMI(8)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .getir_istek_i    (getir_istek),
    .getir_adres_i    (getir_adres),
    .getir_musait_o   (getir_musait_o),
    .getir_hazir_o    (getir_hazir_o),
    .getir_obek_o     (getir_obek_o),
    .veri_istek_i     (veri_istek),
    .veri_adres_i     (veri_adres),
    .veri_yaz_i       (veri_yaz),
    .veri_yaz_obek_i  (veri_yaz_obek),
    .veri_musait_o    (veri_musait_o),
    .veri_hazir_o     (veri_hazir_o),
    .veri_obek_o      (veri_obek_o),
    .bellek_istek_o   (bellek_istek_o),
    .bellek_adres_o   (bellek_adres_o),
    .bellek_yaz_o     (bellek_yaz_o),
    .bellek_oku_o     (bellek_oku_o),
    .bellek_yaz_obek_o(bellek_yaz_obek_o),
    .bellek_kabul_i   (bellek_kabul),
    .bellek_hazir_i   (bellek_hazir),
    .bellek_obek_i    (bellek_obek),
    .hata_o           (hata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] blk(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_0F0F, a ^ 32'hC3C3_0000};
  endfunction

  typedef struct packed {
    logic         veri;
    logic [127:0] obek;
    logic         hata;
  } exp_t;

  exp_t sb[$];

  task automatic push(input logic v, input logic [127:0] o,
                      input logic h);
    exp_t e;
    e.veri = v;
    e.obek = o;
    e.hata = h;
    sb.push_back(e);
  endtask

  // memory model configuration
  int           kabul_wait = 0;
  int           hazir_wait = 0;
  bit           never      = 0;
  bit           use_fn     = 0;
  bit           chk_en     = 0;
  logic [127:0] rdata      = '0;
  logic [31:0]  exp_adres  = '0;
  logic         exp_yaz    = 1'b0;
  logic [127:0] exp_wobek  = '0;

  initial begin
    int           ph;
    int           icnt;
    int           hcnt;
    logic [127:0] rd;
    ph = 0; icnt = 0; hcnt = 0; rd = '0;
    m_kabul = 1'b0; m_hazir = 1'b0; m_obek = '0;
    forever begin
      @(negedge clk);
      m_kabul = 1'b0;
      m_hazir = 1'b0;
      if (!rst || !mem_en) begin
        ph = 0;
        icnt = 0;
      end else if (ph == 0) begin
        if (bellek_istek_o) begin
          chk("yaz_xor_oku", bellek_yaz_o ^ bellek_oku_o, 1);
          if (!never) begin
            if (icnt == kabul_wait) begin
              m_kabul = 1'b1;
              icnt = 0;
              if (chk_en) begin
                chk("mem_adres", bellek_adres_o, exp_adres);
                chk("mem_yaz", bellek_yaz_o, exp_yaz);
                chk("mem_oku", bellek_oku_o, !exp_yaz);
                chk("mem_wobek", bellek_yaz_obek_o, exp_wobek);
              end
              rd = use_fn ? blk(bellek_adres_o) : rdata;
              if (hazir_wait == 0) begin
                m_hazir = 1'b1;
                m_obek = rd;
              end else begin
                ph = 1;
                hcnt = 0;
              end
            end else begin
              icnt++;
            end
          end
        end
      end else begin
        hcnt++;
        if (hcnt == hazir_wait) begin
          m_hazir = 1'b1;
          m_obek = rd;
          ph = 0;
        end
      end
    end
  end

  // monitor: every hazir pulse is matched against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && (getir_hazir_o || veri_hazir_o)) begin
        chk("one_owner", getir_hazir_o & veri_hazir_o, 0);
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("owner_veri", veri_hazir_o, e.veri);
          chk("obek", e.veri ? veri_obek_o : getir_obek_o,
              e.obek);
          chk("other_obek", e.veri ? getir_obek_o : veri_obek_o,
              0);
          chk("hata", hata_o, e.hata);
        end
      end else if (rst && hata_o) begin
        chk("hata_no_pulse", hata_o, 0);
      end
    end
  end

  task automatic wait_pulse(input int maxc, input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge clk);
      got = getir_hazir_o | veri_hazir_o;
    end
    chk(nm, got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pos[$];
    int first;
    rst = 1'b0;
    getir_istek = 0; getir_adres = '0;
    veri_istek = 0; veri_adres = '0; veri_yaz = 0;
    veri_yaz_obek = '0;
    mem_en = 1'b1;
    man_kabul = 0; man_hazir = 0; man_obek = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_getir_musait", getir_musait_o, 0);
    chk("rst_veri_musait", veri_musait_o, 0);
    chk("rst_bellek_istek", bellek_istek_o, 0);
    chk("rst_hazir", {getir_hazir_o, veri_hazir_o, hata_o}, 0);
    chk("rst_obek", getir_obek_o | veri_obek_o, 0);
    rst = 1'b1;
    #1;
    chk("rel_musait", {getir_musait_o, veri_musait_o}, 2'b11);
    @(negedge clk);

    // fetch read, kabul after 1 cycle, hazir after 3
    kabul_wait = 1; hazir_wait = 3; use_fn = 0;
    rdata = {4{32'hA5A5_A5A5}};
    chk_en = 1; exp_adres = 32'h0000_1230; exp_yaz = 0;
    exp_wobek = '0;
    getir_adres = 32'h0000_1234;
    getir_istek = 1;
    push(0, {4{32'hA5A5_A5A5}}, 0);
    @(negedge clk);
    getir_istek = 0;
    chk("istek_high", bellek_istek_o, 1);
    chk("busy_musait", {getir_musait_o, veri_musait_o}, 0);
    wait_pulse(15, "t1_pulse");
    @(negedge clk);
    chk("t1_musait_back", getir_musait_o, 1);

    // both pending, zero-wait: veri, getir, veri, getir
    kabul_wait = 0; hazir_wait = 0; use_fn = 1; chk_en = 0;
    getir_adres = 32'h0000_0100;
    veri_adres = 32'h0000_0200; veri_yaz = 0;
    push(1, blk(32'h200), 0);
    push(0, blk(32'h100), 0);
    push(1, blk(32'h200), 0);
    push(0, blk(32'h100), 0);
    getir_istek = 1; veri_istek = 1;
    pos.delete();
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (getir_hazir_o | veri_hazir_o) pos.push_back(k);
      if (pos.size() == 4) begin
        getir_istek = 0;
        veri_istek = 0;
      end
    end
    chk("rr_count", pos.size(), 4);
    if (pos.size() == 4) begin
      chk("rr_first", pos[0], 2);
      chk("rr_second", pos[1], 5);
      chk("rr_fourth", pos[3], 11);
    end

    // veri write, kabul and hazir in the same cycle
    use_fn = 0; chk_en = 1;
    exp_adres = 32'h8000_0040; exp_yaz = 1;
    exp_wobek = 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00;
    veri_adres = 32'h8000_0040; veri_yaz = 1;
    veri_yaz_obek = exp_wobek;
    push(1, '0, 0);
    veri_istek = 1;
    @(negedge clk);
    veri_istek = 0; veri_yaz = 0;
    wait_pulse(5, "t3_pulse");

    // timeout: memory never accepts
    @(negedge clk);
    chk_en = 0; never = 1;
    getir_adres = 32'h0000_0040;
    push(0, '0, 1);
    getir_istek = 1;
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) getir_istek = 0;
      if ((getir_hazir_o | veri_hazir_o) && first == 0)
        first = k;
      if (k == 10) chk("to_musait_next", getir_musait_o, 1);
    end
    chk("to_pulse_cycle", first, 9);
    never = 0;

    // reset while veri sits in BEKLE
    mem_en = 0;
    veri_adres = 32'h0000_0300; veri_yaz = 0;
    veri_istek = 1;
    @(negedge clk);
    man_kabul = 1; veri_istek = 0;
    @(negedge clk);
    man_kabul = 0;
    chk("bekle_no_istek", bellek_istek_o, 0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_musait", {getir_musait_o, veri_musait_o}, 0);
    chk("mid_rst_out",
        {bellek_istek_o, getir_hazir_o, veri_hazir_o, hata_o}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    man_hazir = 1; man_obek = {4{32'hDEAD_BEEF}};
    @(negedge clk);
    man_hazir = 0;
    chk("late_hazir_ign", {getir_hazir_o, veri_hazir_o}, 0);
    chk("late_musait", veri_musait_o, 1);
    @(negedge clk);

    // tie after reset goes to veri
    mem_en = 1; use_fn = 1;
    getir_adres = 32'h0000_0700;
    veri_adres = 32'h0000_0800;
    push(1, blk(32'h800), 0);
    push(0, blk(32'h700), 0);
    getir_istek = 1; veri_istek = 1;
    @(negedge clk);
    veri_istek = 0;
    wait_pulse(5, "t5_first");
    repeat (2) @(negedge clk);
    getir_istek = 0;
    wait_pulse(5, "t5_second");

    // getir arrives while veri waits in BEKLE
    @(negedge clk);
    kabul_wait = 0; hazir_wait = 3;
    veri_adres = 32'h0000_0500;
    getir_adres = 32'h0000_0600;
    push(1, blk(32'h500), 0);
    push(0, blk(32'h600), 0);
    veri_istek = 1;
    @(negedge clk);
    veri_istek = 0;
    @(negedge clk);
    getir_istek = 1;
    chk("bekle_getir_musait", getir_musait_o, 0);
    wait_pulse(10, "t6_veri");
    repeat (2) @(negedge clk);
    getir_istek = 0;
    wait_pulse(10, "t6_getir");

    for (int i = 0; i < 20 && sb.size() != 0; i++)
      @(negedge clk);
    chk("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/anabellek_hakem.md
# anabellek_hakem

Main-memory arbiter sharing the single 128-bit block port of main memory between the instruction-fetch cache controller (getir) and the data cache controller (veri). Sits between both cache controllers and the memory model. Serialises block read/write transactions with round-robin fairness, a per-transaction response timeout and registered responses routed to the owning requester.

## Interface
- ZAMAN_ASIMI, 255: cycles allowed in ISTEK+BEKLE before timeout abort (≥1)
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- getir_istek_i  in  1  fetch request (level)
- getir_adres_i  in  32  fetch address
- getir_musait_o  out  1  arbiter can accept fetch request this cycle
- getir_hazir_o  out  1  one-cycle pulse: getir_obek_o valid
- getir_obek_o  out  128  block returned to fetch
- veri_istek_i  in  1  data request (level)
- veri_adres_i  in  32  data address
- veri_yaz_i  in  1  1 = block write, 0 = block read
- veri_yaz_obek_i  in  128  write block
- veri_musait_o  out  1  arbiter can accept data request
- veri_hazir_o  out  1  one-cycle pulse: read data valid / write done
- veri_obek_o  out  128  block returned to data cache
- bellek_istek_o  out  1  request to memory, held until accepted
- bellek_adres_o  out  32  block-aligned address
- bellek_yaz_o, bellek_oku_o  out  1 each  exactly one high while bellek_istek_o=1
- bellek_yaz_obek_o  out  128  write block
- bellek_kabul_i  in  1  memory accepts request this cycle
- bellek_hazir_i  in  1  response valid (read data or write ack)
- bellek_obek_i  in  128  read block
- hata_o  out  1  one-cycle pulse on timeout abort

## Operation
- States: BOSTA, ISTEK, BEKLE, YANIT.
- BOSTA: getir_musait_o = veri_musait_o = 1. If any istek high: pick owner, latch address ({adres[31:4],4'h0}), yaz flag (0 for getir), write block; go ISTEK.
- Tie (both istek high): grant the requester not recorded in son_sahip; single request: grant it. son_sahip updated at grant.
- ISTEK: bellek_istek_o=1 with latched fields; on bellek_kabul_i go BEKLE.
- BEKLE: on bellek_hazir_i latch bellek_obek_i (write: latch zero), go YANIT.
- bellek_hazir_i in the same cycle as bellek_kabul_i is legal: go straight to YANIT with data latched.
- YANIT: owner's hazir_o=1 for this cycle with latched block; other requester's hazir_o=0; go BOSTA.
- Timeout counter cleared at grant, incremented each cycle in ISTEK/BEKLE; when it equals ZAMAN_ASIMI without progress to YANIT: hata_o pulse, go YANIT with block 0 (owner still released).
- musait_o=0 in ISTEK/BEKLE/YANIT for both requesters; requests arriving then are ignored until BOSTA.
- bellek_hazir_i outside ISTEK/BEKLE ignored.
- Counter width clog2(ZAMAN_ASIMI+1); no wrap possible.

## Timing
- Reset (rst_i=0, asynchronous): state BOSTA, son_sahip=GETIR (first tie goes to veri), counter 0, all outputs 0 except musait_o outputs 0 during reset and 1 from first cycle in BOSTA after release; obek outputs 0.
- Request sampled at edge N in BOSTA → bellek_istek_o high from N+1.
- Accept at edge M → BEKLE from M+1; hazir at edge K → owner hazir_o high for cycle K+1 only.
- Minimum turnaround (kabul and hazir in first ISTEK cycle): istek→hazir_o 2 cycles; back in BOSTA the cycle after.
- Back-to-back: with both pending continuously, grants alternate veri, getir, veri, …
- Reset mid-transaction aborts immediately; no hazir_o or hata_o pulse emitted.

## Structure
- Package anabellek_paket: state enum (BOSTA, ISTEK, BEKLE, YANIT), sahip enum (GETIR, VERI), OBEK_GENISLIK=128, ADRES_GENISLIK=32.
- Single module; no sub-module needed (round-robin pick is two gates).

## Test plan
- Reset then getir_istek_i=1, adres 0x0000_1234; memory kabul after 1 cycle, hazir after 3 with block 0xA5…A5 → bellek_adres_o=0x0000_1230, bellek_oku_o=1, getir_hazir_o one pulse with 0xA5…A5, veri_hazir_o stays 0.
- Both requesters pending from reset continuously, memory zero-wait → grant order veri, getir, veri, getir; each hazir_o 2 cycles after its grant.
- veri write, adres 0x8000_0040, block 0x1122…; kabul+hazir same cycle → bellek_yaz_o=1, data forwarded unchanged, veri_hazir_o pulse, veri_obek_o=0.
- ZAMAN_ASIMI=8, memory never accepts → after 8 cycles hata_o pulse, owner hazir_o pulse with obek 0, musait_o high next cycle.
- rst_i asserted in BEKLE → outputs 0 asynchronously; late bellek_hazir_i after release ignored; next tie goes to veri.
- getir request raised during veri BEKLE → getir_musait_o=0, getir served only after veri_hazir_o pulse.
